// File: rtl/approx_add_err_monitor_pkg.sv
// Shared parameters and helpers for the approximate-adder error monitor.
package approx_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 32;
  localparam int ACC_W_DEF = 48;

  function automatic int ed_w(input int width);
    return width + 1;
  endfunction

  // True when acc + inc would exceed the all-ones value of a w-bit field (w <= 64).
  function automatic logic sat_add_ovf(input logic [63:0] acc, input logic [63:0] inc, input int w);
    logic [64:0] sum;
    logic [64:0] ceil;
    sum  = {1'b0, acc} + {1'b0, inc};
    ceil = (65'd1 << w) - 65'd1;
    return (sum > ceil);
  endfunction

endpackage

// File: rtl/approx_add_err_calc.sv
// Combinational error distance |exact - approximate| for one adder tuple.
module approx_add_err_calc
  import approx_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int ED_W  = ed_w(WIDTH)
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_cout,
  output logic [ED_W-1:0]  o_ed
);

  logic [ED_W-1:0] w_exact;
  logic [ED_W-1:0] w_approx;

  assign w_exact  = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
  assign w_approx = {i_cout, i_sum};
  assign o_ed     = (w_exact >= w_approx) ? (w_exact - w_approx) : (w_approx - w_exact);

endmodule

// File: rtl/approx_add_err_monitor.sv
// Streaming error-statistics monitor: S1 captures the error distance of each
// accepted tuple, S2 folds it into saturating counters and the running maximum.
module approx_add_err_monitor
  import approx_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  parameter  int ACC_W = ACC_W_DEF,
  localparam int ED_W  = ed_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_a,
  input  logic [WIDTH-1:0] s_b,
  input  logic             s_cin,
  input  logic [WIDTH-1:0] s_sum,
  input  logic             s_cout,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] ed_sum,
  output logic [ED_W-1:0]  ed_max,
  output logic             sat
);

  logic             w_accept;
  logic [ED_W-1:0]  w_ed;
  logic [ACC_W-1:0] w_ed_ext;
  logic             w_ed_nz;
  logic             w_cnt_ovf;
  logic             w_err_ovf;
  logic             w_sum_ovf;

  logic             r_s1_valid;
  logic [ED_W-1:0]  r_s1_ed;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [ACC_W-1:0] r_ed_sum;
  logic [ED_W-1:0]  r_ed_max;
  logic             r_sat;

  approx_add_err_calc #(.WIDTH(WIDTH)) u_calc (
    .i_a    (s_a),
    .i_b    (s_b),
    .i_cin  (s_cin),
    .i_sum  (s_sum),
    .i_cout (s_cout),
    .o_ed   (w_ed)
  );

  // Accounting never stalls, so acceptance is blocked only by reset or clear.
  assign s_ready  = rst_n & ~clear;
  assign w_accept = s_valid & s_ready;

  assign w_ed_ext  = ACC_W'(r_s1_ed);
  assign w_ed_nz   = (r_s1_ed != {ED_W{1'b0}});
  assign w_cnt_ovf = sat_add_ovf(64'(r_sample_cnt), 64'd1, CNT_W);
  assign w_err_ovf = w_ed_nz & sat_add_ovf(64'(r_err_cnt), 64'd1, CNT_W);
  assign w_sum_ovf = sat_add_ovf(64'(r_ed_sum), 64'(r_s1_ed), ACC_W);

  // Reset and clear both drop the in-flight sample and zero every statistic.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_s1_valid   <= 1'b0;
      r_s1_ed      <= {ED_W{1'b0}};
      r_sample_cnt <= {CNT_W{1'b0}};
      r_err_cnt    <= {CNT_W{1'b0}};
      r_ed_sum     <= {ACC_W{1'b0}};
      r_ed_max     <= {ED_W{1'b0}};
      r_sat        <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_ed <= w_ed;
      end
      if (r_s1_valid) begin
        r_sample_cnt <= w_cnt_ovf ? {CNT_W{1'b1}} : (r_sample_cnt + CNT_W'(1));
        if (w_ed_nz) begin
          r_err_cnt <= w_err_ovf ? {CNT_W{1'b1}} : (r_err_cnt + CNT_W'(1));
        end
        r_ed_sum <= w_sum_ovf ? {ACC_W{1'b1}} : (r_ed_sum + w_ed_ext);
        if (r_s1_ed > r_ed_max) begin
          r_ed_max <= r_s1_ed;
        end
        r_sat <= r_sat | w_cnt_ovf | w_err_ovf | w_sum_ovf;
      end
    end
  end

  assign busy       = r_s1_valid;
  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt;
  assign ed_sum     = r_ed_sum;
  assign ed_max     = r_ed_max;
  assign sat        = r_sat;

endmodule

// File: doc/approx_add_err_monitor.md
# approx_add_err_monitor

Streaming error-metric monitor for the approximate adder family (`x16_approx_add` and siblings). Receives operand/result tuples from the adder's output side over a valid/ready stream, recomputes the exact sum, and accumulates error statistics: sample count, error count, error-distance sum and maximum error distance. It sits downstream of the adder under evaluation and replaces exhaustive simulation-only checking with on-chip characterisation.

## Interface
- `WIDTH`, 16, operand/sum width of the monitored adder
- `CNT_W`, 32, width of sample and error counters
- `ACC_W`, 48, width of error-distance accumulator (must be ≥ WIDTH+1)

- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `clear`  in  1  synchronous statistics clear (pulse)
- `s_valid`  in  1  tuple valid
- `s_ready`  out  1  monitor can accept tuple
- `s_a`, `s_b`  in  WIDTH  operands driven to the adder
- `s_cin`  in  1  carry-in driven to the adder
- `s_sum`  in  WIDTH  approximate sum from the adder
- `s_cout`  in  1  approximate carry-out from the adder
- `busy`  out  1  pipeline holds an unaccounted sample
- `sample_cnt`  out  CNT_W  tuples accounted
- `err_cnt`  out  CNT_W  tuples with nonzero error distance
- `ed_sum`  out  ACC_W  sum of error distances
- `ed_max`  out  WIDTH+1  largest error distance seen
- `sat`  out  1  sticky: any counter/accumulator saturated

## Operation
- Exact result E = s_a + s_b + s_cin, WIDTH+1 bits unsigned; approximate result A = {s_cout, s_sum}.
- Error distance ED = |E − A|, WIDTH+1 bits, unsigned; never wraps.
- Two-stage pipeline: S1 registers ED and a valid bit on acceptance; S2 updates statistics from S1.
- S2 update when S1 valid: sample_cnt += 1; if ED≠0 then err_cnt += 1; ed_sum += ED; ed_max = max(ed_max, ED).
- All counters/accumulator saturate at all-ones; any saturation event sets `sat`; saturated fields hold, others keep updating.
- `s_ready` = rst_n deasserted-free and !clear; otherwise always 1 (no backpressure from accounting).
- `clear`: next edge zeroes all statistics, `sat`, and S1 valid (in-flight sample discarded); tuple presented during clear is not accepted.
- `busy` = S1 valid.

## Timing
- Reset (rst_n=0 at edge): all statistics 0, `sat`=0, S1 valid=0, `busy`=0; `s_ready`=0 while rst_n=0.
- Handshake: transfer on edge where s_valid && s_ready; one tuple per cycle sustained.
- Latency: tuple accepted at edge N → ED in S1 after N → statistics reflect it after edge N+1.
- Back-to-back tuples: each counted exactly once, in order; ed_max compares against value including all earlier samples.
- Reset or clear mid-stream: any sample in S1 lost, not counted; first tuple accepted after is counted normally.
- Saturation: increment at all-ones yields all-ones, `sat` rises the same edge.

## Structure
- Shared package `approx_pkg`: default WIDTH, `ED_W = WIDTH+1` function, saturating-add helper function.
- Sub-module `approx_add_err_calc` (combinational: E, A, ED) instantiated before S1; S1/S2 registers and saturation logic in top.

## Test plan
- Reset: rst_n=0 two cycles with s_valid=1 → s_ready=0, all stats 0, busy=0.
- Exact tuple: a=0x1234, b=0x0001, cin=0, sum=0x1235, cout=0 → after 2 cycles sample_cnt=1, err_cnt=0, ed_sum=0, ed_max=0.
- Error tuple: a=0x00FF, b=0x0001, sum=0x00FF, cout=0 → ED=1; then a=0xFFFF, b=0x0001, sum=0x0000, cout=0 → ED=0x10000; result sample_cnt=2, err_cnt=2, ed_sum=0x10001, ed_max=0x10000.
- Streaming: 1000 back-to-back random tuples vs. reference model → counts and sums match exactly, no drop.
- Clear mid-stream: clear asserted the cycle after a valid tuple → that sample not counted, stats 0, next tuple gives sample_cnt=1.
- Saturation: CNT_W=4, 17 tuples with ED=1 → sample_cnt=err_cnt=15, sat=1, ed_sum=17.
